approx_dot_accumulator: RTL and testbench
=========================================

Name: approx_dot_accumulator

Overview:
Streaming multiply-accumulate stage that wraps the 8x8 approximate multiplier. It sits directly around the multiplier:
- Upstream side: accepts operand pairs over a valid/ready handshake, registers them and drives the multiplier inputs.
- Downstream side: samples the 16-bit product one cycle later and accumulates it into a saturating dot-product register.
- Emits one result per vector (ended by in_last or by reaching VEC_LEN elements) over a valid/ready handshake.

Parameters:
- VEC_LEN, 16: maximum elements per vector; the element counter forces end-of-vector when it reaches this value. Range 1..255.
- ACC_W, 24: accumulator and result width. Must be >= 16.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept an operand pair
- in_a  input  8  operand A
- in_b  input  8  operand B
- in_last  input  1  final element of the current vector
- mul_a  output  8  registered operand A to the multiplier
- mul_b  output  8  registered operand B to the multiplier
- mul_p  input  16  combinational product returned by the multiplier
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- out_acc  output  ACC_W  dot-product result
- out_count  output  8  number of elements in the result
- out_sat  output  1  accumulator saturated during this vector

Behaviour:
- Reset (async assert, sync release): state=IDLE; the following are all 0: in_ready, mul_a, mul_b, out_valid, out_acc, out_count, out_sat, acc, cnt, s1_valid, s1_last.
- in_ready: 1 in IDLE and ACCUM; 0 in FLUSH and HOLD. It is a registered output.
- Accept: when in_valid & in_ready, on that edge:
  - mul_a<=in_a, mul_b<=in_b, s1_valid<=1.
  - s1_last <= in_last | (cnt+1==VEC_LEN).
  - cnt<=cnt+1.
  - Otherwise s1_valid<=0, and mul_a/mul_b hold their values.
- Stage 2: when s1_valid, acc <= sat(acc + zero-extended mul_p). If the unsaturated sum exceeds 2^ACC_W-1, acc clamps to all-ones and a sticky sat flag is set.
- FSM:
  - IDLE -> ACCUM on the first accept.
  - ACCUM -> FLUSH on accepting an element with in_last or count-limit; in_ready drops on the same edge.
  - FLUSH: waits one cycle for the stage-2 add to complete. On exit: out_acc<=final acc, out_count<=cnt, out_sat<=sat, out_valid<=1; acc, cnt and sat are cleared. Then -> HOLD.
  - HOLD: out_* held stable while out_valid & !out_ready. On out_valid & out_ready: out_valid<=0, -> IDLE, and in_ready<=1 on the same edge.
- Latency: the last element is accepted at edge N, the product is added at N+1, and out_valid rises at N+2.
- Throughput: 1 element/cycle within a vector. There are 3 bubble cycles between vectors with out_ready tied high.
- Single-element vector (in_last on the first accept): IDLE -> FLUSH directly.
- in_valid low mid-vector: stay in ACCUM; acc is untouched when s1_valid=0.
- Reset mid-vector or in HOLD: everything clears asynchronously; the pending result is discarded.
- Output contents may change only while out_valid=0.

Optional Feature:
Macro APPROX_MEAN_COMP_EN.
- Defined: each stage-2 add uses mul_p + APX_MEAN_COMP (package constant 16'd32, the calibrated mean under-estimate of the multiplier's truncated columns). The add is 17 bits wide before zero-extension, and saturation still applies.
- Undefined: raw mul_p is accumulated, with no extra logic.

Decomposition:
- Package approx_mac_pkg holds:
  - OPERAND_W=8 and PRODUCT_W=16
  - APX_MEAN_COMP
  - state enum {IDLE, ACCUM, FLUSH, HOLD}
- One sub-module, approx_sat_adder: parameterised ACC_W saturating unsigned adder with a sat output, instantiated once for stage 2.
- The multiplier stays external, connected through mul_a/mul_b/mul_p.

Test Plan:
The bench drives mul_p with an exact-product stub (mul_p = mul_a*mul_b) unless stated otherwise. Expected values below assume APPROX_MEAN_COMP_EN undefined.
- Vector of 4 pairs (1,2),(3,4),(5,6),(7,8), in_last on the 4th, out_ready=1 -> out_acc=100, out_count=4, out_sat=0; out_valid 2 cycles after the last accept, asserted for 1 cycle.
- VEC_LEN=16 and 20 pairs of (255,255) with no in_last, ACC_W=16 -> the first result is forced at 16 elements with out_count=16, out_acc=16'hFFFF, out_sat=1. The remaining 4 pairs form a new vector: in_last on the 20th gives out_count=4 and out_acc=260100 clamped to 16'hFFFF, out_sat=1. With ACC_W=24 the first result is 1040400.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_acc/out_count stable, in_ready=0 throughout; the release edge clears out_valid and raises in_ready.
- Single-element vector (9,9,last) followed immediately by a gap of in_valid=0 -> out_acc=81, out_count=1.
- Assert rst_n low one cycle after accepting 2 of 3 elements -> all outputs 0 immediately. The next vector (2,2,last) yields out_acc=4, with no residue.
- With APPROX_MEAN_COMP_EN defined, the vector (1,1),(1,1,last) -> out_acc=66.

Source files
------------

// File: rtl/approx_mac_pkg.sv
// Shared types and constants for the approximate-multiplier MAC wrapper.
package approx_mac_pkg;

  localparam int OPERAND_W = 8;
  localparam int PRODUCT_W = 16;

  // Calibrated mean under-estimate of the multiplier's truncated partial-product columns.
  localparam logic [PRODUCT_W-1:0] APX_MEAN_COMP = 16'd32;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    FLUSH,
    HOLD
  } state_e;

endpackage

// File: rtl/approx_sat_adder.sv
// Unsigned saturating adder: y = min(a + b, 2^ACC_W - 1), sat flags the clamp.
module approx_sat_adder #(
  parameter int ACC_W = 24,
  parameter int B_W   = 16
) (
  input  logic [ACC_W-1:0] a,
  input  logic [B_W-1:0]   b,
  output logic [ACC_W-1:0] y,
  output logic             sat
);

  localparam int SUM_W = ((ACC_W > B_W) ? ACC_W : B_W) + 1;

  function automatic logic [ACC_W-1:0] sat_clip(input logic [SUM_W-1:0] s);
    if (|s[SUM_W-1:ACC_W]) return '1;
    return s[ACC_W-1:0];
  endfunction

  logic [SUM_W-1:0] sum;

  assign sum = SUM_W'(a) + SUM_W'(b);
  assign sat = |sum[SUM_W-1:ACC_W];
  assign y   = sat_clip(sum);

endmodule

// File: rtl/approx_dot_accumulator.sv
// Streaming saturating dot-product accumulator around an external 8x8 approximate multiplier.
// Optional: define APPROX_MEAN_COMP_EN to add APX_MEAN_COMP to every product before accumulation.
module approx_dot_accumulator
  import approx_mac_pkg::*;
#(
  parameter int VEC_LEN = 16,
  parameter int ACC_W   = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPERAND_W-1:0] in_a,
  input  logic [OPERAND_W-1:0] in_b,
  input  logic                 in_last,
  output logic [OPERAND_W-1:0] mul_a,
  output logic [OPERAND_W-1:0] mul_b,
  input  logic [PRODUCT_W-1:0] mul_p,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W-1:0]     out_acc,
  output logic [7:0]           out_count,
  output logic                 out_sat
);

`ifdef APPROX_MEAN_COMP_EN
  localparam int ADD_W = PRODUCT_W + 1;
  logic [ADD_W-1:0] addend;
  assign addend = {1'b0, mul_p} + {1'b0, APX_MEAN_COMP};
`else
  localparam int ADD_W = PRODUCT_W;
  logic [ADD_W-1:0] addend;
  assign addend = mul_p;
`endif

  state_e                 state_q, state_d;
  logic                   in_ready_q, in_ready_d;
  logic [OPERAND_W-1:0]   mul_a_q, mul_a_d;
  logic [OPERAND_W-1:0]   mul_b_q, mul_b_d;
  logic                   vld_p1_q, vld_p1_d;
  logic                   last_p1_q, last_p1_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [ACC_W-1:0]       acc_p2_q, acc_p2_d;
  logic                   sat_p2_q, sat_p2_d;
  logic                   out_valid_q, out_valid_d;
  logic [ACC_W-1:0]       out_acc_q, out_acc_d;
  logic [7:0]             out_count_q, out_count_d;
  logic                   out_sat_q, out_sat_d;

  logic                   accept;
  logic                   hit_len;
  logic                   end_vec;
  logic [ACC_W-1:0]       acc_sum;
  logic                   acc_ovf;

  approx_sat_adder #(
    .ACC_W (ACC_W),
    .B_W   (ADD_W)
  ) u_sat_add (
    .a   (acc_p2_q),
    .b   (addend),
    .y   (acc_sum),
    .sat (acc_ovf)
  );

  assign accept  = in_valid & in_ready_q;
  assign hit_len = (({1'b0, cnt_q} + 9'd1) == 9'(VEC_LEN));
  assign end_vec = in_last | hit_len;

  always_comb begin
    state_d     = state_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    vld_p1_d    = 1'b0;
    last_p1_d   = 1'b0;
    cnt_d       = cnt_q;
    acc_p2_d    = acc_p2_q;
    sat_p2_d    = sat_p2_q;
    out_valid_d = out_valid_q;
    out_acc_d   = out_acc_q;
    out_count_d = out_count_q;
    out_sat_d   = out_sat_q;

    // stage 1: operand capture toward the multiplier
    if (accept) begin
      mul_a_d   = in_a;
      mul_b_d   = in_b;
      vld_p1_d  = 1'b1;
      last_p1_d = end_vec;
      cnt_d     = cnt_q + 8'd1;
      state_d   = end_vec ? FLUSH : ACCUM;
    end

    // stage 2: saturating accumulate of the returned product
    if (vld_p1_q) begin
      acc_p2_d = acc_sum;
      sat_p2_d = sat_p2_q | acc_ovf;
    end

    case (state_q)
      FLUSH: begin
        // The final element's add lands on the first FLUSH edge; publish on the next one.
        if (!(vld_p1_q & last_p1_q)) begin
          out_acc_d   = acc_p2_q;
          out_count_d = cnt_q;
          out_sat_d   = sat_p2_q;
          out_valid_d = 1'b1;
          acc_p2_d    = '0;
          cnt_d       = '0;
          sat_p2_d    = 1'b0;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (out_valid_q & out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: ;
    endcase

    in_ready_d = (state_d == IDLE) || (state_d == ACCUM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      vld_p1_q    <= 1'b0;
      last_p1_q   <= 1'b0;
      cnt_q       <= '0;
      acc_p2_q    <= '0;
      sat_p2_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_count_q <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      vld_p1_q    <= vld_p1_d;
      last_p1_q   <= last_p1_d;
      cnt_q       <= cnt_d;
      acc_p2_q    <= acc_p2_d;
      sat_p2_q    <= sat_p2_d;
      out_valid_q <= out_valid_d;
      out_acc_q   <= out_acc_d;
      out_count_q <= out_count_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign out_count = out_count_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_approx_dot_accumulator.sv
// Directed bench: two accumulators (ACC_W=24 and ACC_W=16) fed identical operand streams.
module tb_approx_dot_accumulator;

`ifdef APPROX_MEAN_COMP_EN
  localparam int C = 32;
`else
  localparam int C = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        in_last;
  logic        out_ready;

  logic        in_ready, in_ready16;
  logic [7:0]  mul_a, mul_b, mul_a16, mul_b16;
  logic [15:0] mul_p, mul_p16;
  logic        out_valid, out_valid16;
  logic [23:0] out_acc;
  logic [15:0] out_acc16;
  logic [7:0]  out_count, out_count16;
  logic        out_sat, out_sat16;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [23:0] acc24;
    logic [15:0] acc16;
    logic [7:0]  cnt;
    logic        sat24;
    logic        sat16;
  } res_t;

  res_t res_q[$];

  assign mul_p   = mul_a * mul_b;
  assign mul_p16 = mul_a16 * mul_b16;

  approx_dot_accumulator #(.VEC_LEN(16), .ACC_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_count(out_count), .out_sat(out_sat)
  );

  approx_dot_accumulator #(.VEC_LEN(16), .ACC_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .mul_a(mul_a16), .mul_b(mul_b16), .mul_p(mul_p16),
    .out_valid(out_valid16), .out_ready(out_ready),
    .out_acc(out_acc16), .out_count(out_count16), .out_sat(out_sat16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every completed output handshake of both instances.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      res_q.push_back('{acc24: out_acc, acc16: out_acc16, cnt: out_count,
                        sat24: out_sat, sat16: out_sat16});
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
    bit done;
    done = 1'b0;
    in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
    for (int n = 0; n < 64 && !done; n++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic get_result(output res_t r);
    int n;
    n = 0;
    while (res_q.size() == 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (res_q.size() == 0) begin
      check("result_timeout", 32'd0, 32'd1);
      r = '{acc24: '0, acc16: '0, cnt: '0, sat24: 1'b0, sat16: 1'b0};
    end else begin
      r = res_q.pop_front();
    end
  endtask

  initial begin
    res_t r;
    int   lat;

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_acc", out_acc, 0);
    check("rst_mul_a", mul_a, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", in_ready, 1);

    // 4-element vector: 1*2+3*4+5*6+7*8 = 100
    send(8'd1, 8'd2, 1'b0);
    send(8'd3, 8'd4, 1'b0);
    send(8'd5, 8'd6, 1'b0);
    send(8'd7, 8'd8, 1'b1);
    lat = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    check("vec4_latency", lat, 3);
    @(posedge clk); #1;
    @(negedge clk);
    check("vec4_valid_pulse", out_valid, 0);
    get_result(r);
    check("vec4_acc", r.acc24, 100 + 4 * C);
    check("vec4_acc16", r.acc16, 100 + 4 * C);
    check("vec4_count", r.cnt, 4);
    check("vec4_sat", r.sat24, 0);
    @(posedge clk); #1;

    // 20 x (255,255): forced split at 16 elements, then a 4-element vector
    for (int i = 0; i < 20; i++) send(8'd255, 8'd255, (i == 19));
    get_result(r);
    check("len_acc24", r.acc24, 1040400 + 16 * C);
    check("len_sat24", r.sat24, 0);
    check("len_acc16", r.acc16, 32'hFFFF);
    check("len_sat16", r.sat16, 1);
    check("len_count", r.cnt, 16);
    get_result(r);
    check("tail_acc24", r.acc24, 260100 + 4 * C);
    check("tail_sat24", r.sat24, 0);
    check("tail_acc16", r.acc16, 32'hFFFF);
    check("tail_sat16", r.sat16, 1);
    check("tail_count", r.cnt, 4);

    // Backpressure: 3*3+4*4 = 25 held for 5 cycles
    out_ready = 1'b0;
    send(8'd3, 8'd3, 1'b0);
    send(8'd4, 8'd4, 1'b1);
    for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", out_valid, 1);
      check("bp_acc", out_acc, 25 + 2 * C);
      check("bp_count", out_count, 2);
      check("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", out_valid, 0);
    check("bp_release_in_ready", in_ready, 1);
    get_result(r);
    check("bp_result", r.acc24, 25 + 2 * C);

    // Single-element vector followed by an idle gap
    send(8'd9, 8'd9, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    get_result(r);
    check("single_acc", r.acc24, 81 + C);
    check("single_count", r.cnt, 1);
    repeat (2) begin @(posedge clk); #1; end

    // Reset mid-vector discards the partial result
    send(8'd5, 8'd5, 1'b0);
    send(8'd6, 8'd6, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mrst_mul_a", mul_a, 0);
    check("mrst_mul_b", mul_b, 0);
    check("mrst_in_ready", in_ready, 0);
    check("mrst_out_valid", out_valid, 0);
    check("mrst_out_acc", out_acc, 0);
    check("mrst_out_count", out_count, 0);
    check("mrst_out_sat", out_sat, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mrst_no_result", res_q.size(), 0);
    send(8'd2, 8'd2, 1'b1);
    get_result(r);
    check("post_rst_acc", r.acc24, 4 + C);
    check("post_rst_count", r.cnt, 1);
    @(posedge clk); #1;

    // (1,1),(1,1,last): 2 raw, 66 with mean compensation
    send(8'd1, 8'd1, 1'b0);
    send(8'd1, 8'd1, 1'b1);
    get_result(r);
    check("comp_acc", r.acc24, 2 + 2 * C);
    check("comp_sat", r.sat24, 0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
